// File: rtl/uart_host_ctrl_if.sv
// Signal bundle between uart_host_ctrl and its surroundings: the user
// transmit/receive streams on one side and the UART core's chip-select
// register port on the other. The controller uses the master modport; the
// fabric/core side uses the slave modport.
interface uart_host_ctrl_if;
  // User transmit stream
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  // User receive stream
  logic [7:0] rx_data;
  logic       rx_perr;
  logic       rx_ferr;
  logic       rx_valid;
  logic       rx_ready;
  // UART core register port
  logic       CSN;
  logic       WEN;
  logic       OEN;
  logic [7:0] DATA_IN;
  logic [7:0] DATA_OUT;
  logic       TXRDY;
  logic       RXRDY;
  logic       PARITY_ERR;
  logic       FRAMING_ERR;
  logic       OVERFLOW;

  modport master (
    input  tx_data, tx_valid, rx_ready,
    input  DATA_OUT, TXRDY, RXRDY, PARITY_ERR, FRAMING_ERR, OVERFLOW,
    output tx_ready, rx_data, rx_perr, rx_ferr, rx_valid,
    output CSN, WEN, OEN, DATA_IN
  );

  modport slave (
    output tx_data, tx_valid, rx_ready,
    output DATA_OUT, TXRDY, RXRDY, PARITY_ERR, FRAMING_ERR, OVERFLOW,
    input  tx_ready, rx_data, rx_perr, rx_ferr, rx_valid,
    input  CSN, WEN, OEN, DATA_IN
  );
endinterface

// File: rtl/uart_host_ctrl.sv
// Bus-side initiator for the UART core. Turns a user transmit stream into
// one-cycle write strobes, polls RXRDY to issue one-cycle read strobes, and
// presents each received byte with its error flags on a user receive stream.
// After every strobe the core status is ignored for HOLDOFF cycles so a
// stale TXRDY/RXRDY cannot trigger a second access. Also keeps a saturating
// count of core OVERFLOW events.
module uart_host_ctrl #(
  parameter int HOLDOFF   = 2,  // 1..15
  parameter int OVF_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  uart_host_ctrl_if.master     bus,
  output logic [OVF_CNT_W-1:0] ovf_count
);

  typedef enum logic [1:0] {IDLE, WR, RD, HOLD} state_t;
  typedef enum logic {GRANT_RD = 1'b0, GRANT_WR = 1'b1} grant_t;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF - 1);

  state_t                 state_q;
  grant_t                 last_grant_q;
  logic [3:0]             hold_cnt_q;
  logic                   csn_q, wen_q, oen_q;
  logic [7:0]             data_in_q;
  logic [7:0]             rx_data_q;
  logic                   rx_perr_q, rx_ferr_q, rx_valid_q;
  logic                   ovf_sync_q, ovf_prev_q;
  logic [OVF_CNT_W-1:0]   ovf_cnt_q, ovf_cnt_d;

  logic                   rd_req, wr_req, rd_grant, wr_grant, rx_consume;

  // Request qualification and round-robin arbitration, only meaningful in IDLE.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a value unassigned, which would infer a latch.
    rd_grant   = 1'b0;
    wr_grant   = 1'b0;
    rx_consume = rx_valid_q & bus.rx_ready;
    // A slot being consumed this cycle counts as free.
    rd_req     = bus.RXRDY & (~rx_valid_q | bus.rx_ready);
    wr_req     = bus.tx_valid & bus.TXRDY;
    if (RESET_N && state_q == IDLE) begin
      if (rd_req && wr_req) begin
        wr_grant = (last_grant_q == GRANT_RD);
        rd_grant = ~wr_grant;
      end else begin
        rd_grant = rd_req;
        wr_grant = wr_req;
      end
    end
  end

  // Access sequencer: one-cycle strobe, then HOLDOFF cycles of settling.
  always_ff @(posedge CLK or negedge RESET_N) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!RESET_N) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_RD;
      hold_cnt_q   <= 4'd0;
      csn_q        <= 1'b1;
      wen_q        <= 1'b1;
      oen_q        <= 1'b1;
      data_in_q    <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_grant) begin
            data_in_q <= bus.tx_data;
            csn_q     <= 1'b0;
            wen_q     <= 1'b0;
            state_q   <= WR;
          end else if (rd_grant) begin
            csn_q   <= 1'b0;
            oen_q   <= 1'b0;
            state_q <= RD;
          end
        end
        WR: begin
          csn_q        <= 1'b1;
          wen_q        <= 1'b1;
          last_grant_q <= GRANT_WR;
          hold_cnt_q   <= HOLD_LOAD;
          state_q      <= HOLD;
        end
        RD: begin
          csn_q        <= 1'b1;
          oen_q        <= 1'b1;
          last_grant_q <= GRANT_RD;
          hold_cnt_q   <= HOLD_LOAD;
          state_q      <= HOLD;
        end
        HOLD: begin
          if (hold_cnt_q == 4'd0) state_q <= IDLE;
          else                    hold_cnt_q <= hold_cnt_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Receive holding register: capture at the end of the read strobe; a
  // capture wins over a simultaneous consume.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_data_q  <= 8'h00;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_valid_q <= 1'b0;
    end else if (state_q == RD) begin
      rx_data_q  <= bus.DATA_OUT;
      rx_perr_q  <= bus.PARITY_ERR;
      rx_ferr_q  <= bus.FRAMING_ERR;
      rx_valid_q <= 1'b1;
    end else if (rx_consume) begin
      rx_valid_q <= 1'b0;
    end
  end

  // Saturating increment on a registered 0->1 edge of OVERFLOW.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (ovf_sync_q && !ovf_prev_q && ovf_cnt_q != '1)
      ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
  end

  // Overflow edge history and event counter.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ovf_sync_q <= 1'b0;
      ovf_prev_q <= 1'b0;
      ovf_cnt_q  <= '0;
    end else begin
      ovf_sync_q <= bus.OVERFLOW;
      ovf_prev_q <= ovf_sync_q;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  assign bus.tx_ready = wr_grant;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_perr  = rx_perr_q;
  assign bus.rx_ferr  = rx_ferr_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.CSN      = csn_q;
  assign bus.WEN      = wen_q;
  assign bus.OEN      = oen_q;
  assign bus.DATA_IN  = data_in_q;
  assign ovf_count    = ovf_cnt_q;

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Testbench for uart_host_ctrl: directed stimulus with literal expectations,
// plus a negedge monitor holding a transaction-level model of the streams.
module tb_uart_host_ctrl;
  localparam int HOLDOFF   = 2;
  localparam int OVF_CNT_W = 8;
  localparam int PERIOD    = HOLDOFF + 2;

  logic                 CLK = 1'b0;
  logic                 RESET_N = 1'b0;
  logic [OVF_CNT_W-1:0] ovf_count;

  uart_host_ctrl_if bus();

  uart_host_ctrl #(.HOLDOFF(HOLDOFF), .OVF_CNT_W(OVF_CNT_W)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .bus       (bus),
    .ovf_count (ovf_count)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic neg();
    @(negedge CLK);
  endtask

  // ---------------------------------------------------------------------
  // Cycle monitor: stream-level model of what the controller may do.
  // ---------------------------------------------------------------------
  logic        p_hs, p_rd_req, p_rd_strobe, p_exp_valid, p_rx_ready;
  logic [7:0]  p_hs_data;
  logic [9:0]  pend, held;   // {perr, ferr, data}
  int          last_strobe;

  always @(negedge CLK) begin : monitor
    logic s_wr, s_rd, ev;
    if (!RESET_N) begin
      p_hs        = 1'b0;
      p_rd_req    = 1'b0;
      p_rd_strobe = 1'b0;
      p_exp_valid = 1'b0;
      p_rx_ready  = 1'b0;
      p_hs_data   = 8'h00;
      pend        = '0;
      held        = '0;
      last_strobe = -100;
    end else begin
      s_wr = !bus.CSN && !bus.WEN;
      s_rd = !bus.CSN && !bus.OEN;
      if (!bus.CSN || !bus.WEN || !bus.OEN)
        check("strobe_shape", {bus.CSN, bus.WEN & bus.OEN, ~(bus.WEN | bus.OEN)}, 3'b000);
      if (bus.tx_ready)
        check("tx_ready_cond", {bus.tx_valid, bus.TXRDY}, 2'b11);
      if (s_wr || p_hs)
        check("wr_follows_handshake", s_wr, p_hs);
      if (s_wr)
        check("wr_data", bus.DATA_IN, p_hs_data);
      if (s_rd)
        check("rd_allowed", p_rd_req, 1'b1);
      if (s_wr || s_rd) begin
        check("strobe_spacing_min", (cyc - last_strobe) >= PERIOD, 1'b1);
        last_strobe = cyc;
      end
      // Receive stream model: a read strobe delivers its byte next cycle;
      // an unconsumed byte stays; a consumed one leaves.
      if (p_rd_strobe) begin
        held = pend;
        ev   = 1'b1;
      end else if (p_exp_valid && !p_rx_ready) begin
        ev = 1'b1;
      end else begin
        ev = 1'b0;
      end
      check("rx_valid_model", bus.rx_valid, ev);
      if (ev)
        check("rx_payload_model", {bus.rx_perr, bus.rx_ferr, bus.rx_data}, held);
      if (s_rd) pend = {bus.PARITY_ERR, bus.FRAMING_ERR, bus.DATA_OUT};
      p_hs        = bus.tx_valid & bus.tx_ready;
      p_hs_data   = bus.tx_data;
      p_rd_req    = bus.RXRDY & (~ev | bus.rx_ready);
      p_rd_strobe = s_rd;
      p_exp_valid = ev;
      p_rx_ready  = bus.rx_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------
  task automatic ovf_pulses(input int n);
    repeat (n) begin
      bus.OVERFLOW = 1'b1;
      tick();
      bus.OVERFLOW = 1'b0;
      tick();
    end
  endtask

  initial begin
    int       n_str;
    logic [3:0] seq;
    int       t [4];
    logic     found;

    bus.tx_data = 8'h00; bus.tx_valid = 1'b0; bus.rx_ready = 1'b0;
    bus.DATA_OUT = 8'h00; bus.TXRDY = 1'b0; bus.RXRDY = 1'b0;
    bus.PARITY_ERR = 1'b0; bus.FRAMING_ERR = 1'b0; bus.OVERFLOW = 1'b0;
    t = '{default: 0};

    // Reset state, with a pending transmit request that must not be accepted.
    bus.tx_valid = 1'b1; bus.TXRDY = 1'b1; bus.tx_data = 8'hEE;
    repeat (2) neg();
    check("reset_strobes", {bus.CSN, bus.WEN, bus.OEN}, 3'b111);
    check("reset_data_in", bus.DATA_IN, 8'h00);
    check("reset_rx", {bus.rx_valid, bus.rx_perr, bus.rx_ferr, bus.rx_data}, 11'h000);
    check("reset_tx_ready", bus.tx_ready, 1'b0);
    check("reset_ovf", ovf_count, 8'd0);
    tick();
    bus.tx_valid = 1'b0; bus.TXRDY = 1'b0;
    RESET_N = 1'b1;
    tick();

    // Single write, then a second byte showing the holdoff spacing.
    bus.TXRDY = 1'b1; bus.tx_data = 8'hA5; bus.tx_valid = 1'b1;
    neg(); check("wr_tx_ready", bus.tx_ready, 1'b1);
    tick(); bus.tx_data = 8'h5A;
    neg(); check("wr_strobe", {bus.tx_ready, bus.CSN, bus.WEN, bus.OEN, bus.DATA_IN}, {4'b0001, 8'hA5});
    repeat (2) begin
      tick(); neg();
      check("wr_holdoff", {bus.tx_ready, bus.CSN, bus.WEN, bus.OEN}, 4'b0111);
    end
    tick(); neg(); check("wr_second_grant", bus.tx_ready, 1'b1);
    tick(); bus.tx_valid = 1'b0;
    neg(); check("wr_second_strobe", {bus.CSN, bus.WEN, bus.OEN, bus.DATA_IN}, {3'b001, 8'h5A});
    repeat (4) tick();
    bus.TXRDY = 1'b0;

    // Single read with a parity error.
    bus.RXRDY = 1'b1; bus.DATA_OUT = 8'h3C; bus.PARITY_ERR = 1'b1; bus.FRAMING_ERR = 1'b0;
    neg(); check("rd_grant_cycle", {bus.CSN, bus.WEN, bus.OEN}, 3'b111);
    tick(); neg(); check("rd_strobe", {bus.CSN, bus.WEN, bus.OEN}, 3'b010);
    tick(); bus.RXRDY = 1'b0; bus.DATA_OUT = 8'hFF; bus.PARITY_ERR = 1'b0;
    neg(); check("rd_capture", {bus.rx_valid, bus.rx_perr, bus.rx_ferr, bus.rx_data}, {3'b110, 8'h3C});

    // Back-pressure: byte held, core keeps RXRDY high, no read for 20 cycles.
    tick();
    bus.RXRDY = 1'b1; bus.DATA_OUT = 8'h77; bus.PARITY_ERR = 1'b0; bus.FRAMING_ERR = 1'b1;
    for (int i = 0; i < 20; i++) begin
      neg(); check("bp_no_read", bus.OEN, 1'b1);
      tick();
    end
    bus.rx_ready = 1'b1;
    neg(); check("bp_release_grant", {bus.rx_valid, bus.CSN, bus.OEN}, 3'b111);
    tick(); neg(); check("bp_read_strobe", {bus.rx_valid, bus.CSN, bus.WEN, bus.OEN}, 4'b0010);
    tick(); bus.RXRDY = 1'b0;
    neg(); check("bp_new_byte", {bus.rx_valid, bus.rx_perr, bus.rx_ferr, bus.rx_data}, {3'b101, 8'h77});
    repeat (4) tick();

    // Reset so last_grant starts at RD, then contention between both paths.
    RESET_N = 1'b0;
    repeat (2) tick();
    RESET_N = 1'b1;
    tick();
    bus.RXRDY = 1'b1; bus.TXRDY = 1'b1; bus.tx_valid = 1'b1; bus.tx_data = 8'hC3;
    bus.DATA_OUT = 8'h96; bus.PARITY_ERR = 1'b0; bus.FRAMING_ERR = 1'b0; bus.rx_ready = 1'b1;
    n_str = 0; seq = 4'b0000;
    for (int i = 0; i < 40 && n_str < 4; i++) begin
      neg();
      if (!bus.CSN) begin
        seq[3 - n_str] = !bus.WEN;
        t[n_str] = cyc;
        n_str++;
      end
      tick();
    end
    bus.RXRDY = 1'b0; bus.TXRDY = 1'b0; bus.tx_valid = 1'b0;
    check("contention_count", n_str, 4);
    check("contention_order_WRWR", seq, 4'b1010);
    for (int k = 1; k < 4; k++)
      check("contention_spacing", t[k] - t[k-1], PERIOD);
    repeat (6) tick();

    // Overflow counting: a long level counts once, then pulses saturate.
    bus.OVERFLOW = 1'b1;
    repeat (10) tick();
    bus.OVERFLOW = 1'b0;
    repeat (4) tick();
    neg(); check("ovf_level_once", ovf_count, 8'd1);
    tick();
    ovf_pulses(10);
    repeat (3) tick();
    neg(); check("ovf_after_11", ovf_count, 8'd11);
    tick();
    ovf_pulses(290);
    repeat (3) tick();
    neg(); check("ovf_saturated", ovf_count, 8'd255);
    tick();
    ovf_pulses(2);
    repeat (3) tick();
    neg(); check("ovf_holds_at_max", ovf_count, 8'd255);

    // Reset in the middle of a read strobe.
    tick();
    bus.rx_ready = 1'b0; bus.RXRDY = 1'b1;
    bus.DATA_OUT = 8'hE1; bus.PARITY_ERR = 1'b0; bus.FRAMING_ERR = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      neg();
      if (!bus.OEN) begin found = 1'b1; break; end
      tick();
    end
    check("rmr_strobe_seen", found, 1'b1);
    #2 RESET_N = 1'b0;
    #1;
    check("rmr_async_strobes", {bus.CSN, bus.WEN, bus.OEN}, 3'b111);
    check("rmr_rx_valid", bus.rx_valid, 1'b0);
    repeat (2) tick();
    neg(); check("rmr_no_capture", bus.rx_valid, 1'b0);
    tick();
    bus.DATA_OUT = 8'h4B; bus.PARITY_ERR = 1'b1; bus.FRAMING_ERR = 1'b0;
    RESET_N = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      neg();
      if (!bus.OEN) begin found = 1'b1; break; end
      tick();
    end
    check("rmr_read_after_reset", found, 1'b1);
    tick(); bus.RXRDY = 1'b0;
    neg(); check("rmr_capture", {bus.rx_valid, bus.rx_perr, bus.rx_ferr, bus.rx_data}, {3'b110, 8'h4B});
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
